// File: rtl/contador_desc_if.sv
// contador_desc_if
//   Control/status bundle for the contador_desc down counter (timer).
//   Parameter:
//     WIDTH        counter / load value width in bits (must match the counter)
//   Signals:
//     start        1 = load load_val and (re)start counting
//     load_val     start/reload value, captured only with start
//     auto_reload  captured with start; 1 = periodic, 0 = one-shot
//     en           count enable; 0 = hold count and state
//     Q            current count (registered)
//     busy         1 while counting
//     tc           terminal-count pulse, one cycle, registered
//     done         1 once a one-shot count has finished
//   Modports:
//     master       the block driving the counter (drives controls, reads status)
//     slave        the counter itself
interface contador_desc_if #(
  parameter int unsigned WIDTH = 4
) ();

  logic             start;
  logic [WIDTH-1:0] load_val;
  logic             auto_reload;
  logic             en;
  logic [WIDTH-1:0] Q;
  logic             busy;
  logic             tc;
  logic             done;

  modport master (
    output start,
    output load_val,
    output auto_reload,
    output en,
    input  Q,
    input  busy,
    input  tc,
    input  done
  );

  modport slave (
    input  start,
    input  load_val,
    input  auto_reload,
    input  en,
    output Q,
    output busy,
    output tc,
    output done
  );

endinterface

// File: rtl/contador_desc.sv
// contador_desc
//   Synchronous programmable down counter (timer). Loads a start value,
//   decrements once per enabled clock to 0, and flags terminal count with a
//   registered one-cycle tc pulse. One-shot mode parks in DONE with Q=0;
//   auto-reload mode reloads the captured value and keeps running, giving a
//   period of reload+1 enabled cycles. Single clock domain.
//
//   Parameter:
//     WIDTH   counter / load value width in bits (>= 2)
//   Ports:
//     clk     system clock, rising edge
//     CLR     asynchronous active-high clear of all state
//     PR      synchronous preset to max-period free-run; only present when
//             the macro CONTADOR_DESC_PR_EN is defined
//     bus     contador_desc_if slave: start, load_val, auto_reload, en in;
//             Q, busy, tc, done out
//
//   Edge priority: CLR > PR (if compiled) > start > enabled count.
//   busy and done are plain decodes of the state register.
module contador_desc #(
  parameter int unsigned WIDTH = 4
) (
  input  logic            clk,
  input  logic            CLR,
`ifdef CONTADOR_DESC_PR_EN
  input  logic            PR,
`endif
  contador_desc_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] reload_reg;
  logic             mode_reg;
  logic             tc_r;

  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      state      <= ST_IDLE;
      q_r        <= '0;
      reload_reg <= '0;
      mode_reg   <= 1'b0;
      tc_r       <= 1'b0;
    end else begin
      // tc is a pulse: dropped on every edge unless the terminal-count branch
      // below re-asserts it.
      tc_r <= 1'b0;
`ifdef CONTADOR_DESC_PR_EN
      if (PR) begin
        q_r        <= '1;
        reload_reg <= '1;
        mode_reg   <= 1'b1;
        state      <= ST_RUN;
      end else
`endif
      if (bus.start) begin
        // Restart from any state; a terminal count pending this edge is
        // discarded because tc stays at its cleared default.
        q_r        <= bus.load_val;
        reload_reg <= bus.load_val;
        mode_reg   <= bus.auto_reload;
        state      <= ST_RUN;
      end else if ((state == ST_RUN) && bus.en) begin
        if (q_r != '0) begin
          q_r <= q_r - WIDTH'(1);
        end else begin
          tc_r <= 1'b1;
          if (mode_reg) begin
            q_r <= reload_reg;
          end else begin
            state <= ST_DONE;
          end
        end
      end
    end
  end

  assign bus.Q    = q_r;
  assign bus.tc   = tc_r;
  assign bus.busy = (state == ST_RUN);
  assign bus.done = (state == ST_DONE);

endmodule

// File: tb/tb_contador_desc.sv
module tb_contador_desc;

  localparam int unsigned W = 4;

  typedef struct {
    string      tag;
    logic [3:0] q;
    logic       busy;
    logic       tc;
    logic       done;
  } exp_t;

  logic clk;
  logic CLR;
`ifdef CONTADOR_DESC_PR_EN
  logic PR;
`endif

  int checks   = 0;
  int failures = 0;
  exp_t sb[$];

  contador_desc_if #(.WIDTH(W)) bus ();

  contador_desc #(.WIDTH(W)) dut (
    .clk (clk),
    .CLR (CLR),
`ifdef CONTADOR_DESC_PR_EN
    .PR  (PR),
`endif
    .bus (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic push_exp(input string tag, input logic [3:0] q,
                          input logic b, input logic t, input logic d);
    exp_t e;
    e.tag = tag; e.q = q; e.busy = b; e.tc = t; e.done = d;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty got=0 entries want>=1");
    end else begin
      e = sb.pop_front();
      checks++;
      assert ({bus.Q, bus.busy, bus.tc, bus.done} === {e.q, e.busy, e.tc, e.done})
      else begin
        failures++;
        $error("FAIL %s Q/busy/tc/done got=%h/%b/%b/%b want=%h/%b/%b/%b",
               e.tag, bus.Q, bus.busy, bus.tc, bus.done,
               e.q, e.busy, e.tc, e.done);
      end
    end
  endtask

  // Drive one cycle of inputs, queue the state expected after the next
  // rising edge, then sample 1 ns past that edge.
  task automatic cyc(input logic s, input logic [3:0] lv, input logic ar,
                     input logic e, input logic [3:0] eq, input logic eb,
                     input logic et, input logic ed, input string tag);
    bus.start       = s;
    bus.load_val    = lv;
    bus.auto_reload = ar;
    bus.en          = e;
    push_exp(tag, eq, eb, et, ed);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  initial begin
    CLR             = 1'b1;
`ifdef CONTADOR_DESC_PR_EN
    PR              = 1'b0;
`endif
    bus.start       = 1'b0;
    bus.load_val    = '0;
    bus.auto_reload = 1'b0;
    bus.en          = 1'b0;

    // reset state
    #5;
    push_exp("reset", 4'd0, 1'b0, 1'b0, 1'b0);
    pop_check();
    #10;
    CLR = 1'b0;

    // 1: one-shot load 5
    cyc(1, 4'd5, 0, 1, 4'd5, 1, 0, 0, "t1_load");
    for (int i = 4; i >= 0; i--)
      cyc(0, 4'd0, 0, 1, 4'(i), 1, 0, 0, "t1_dec");
    cyc(0, 4'd0, 0, 1, 4'd0, 0, 1, 1, "t1_tc");
    cyc(0, 4'd0, 0, 1, 4'd0, 0, 0, 1, "t1_done_hold");
    cyc(0, 4'd0, 0, 0, 4'd0, 0, 0, 1, "t1_done_hold_en0");

    // 2: auto-reload load 3, period 4
    cyc(1, 4'd3, 1, 1, 4'd3, 1, 0, 0, "t2_load");
    for (int p = 0; p < 3; p++) begin
      for (int k = 2; k >= 0; k--)
        cyc(0, 4'd0, 0, 1, 4'(k), 1, 0, 0, "t2_dec");
      cyc(0, 4'd0, 0, 1, 4'd3, 1, 1, 0, "t2_tc_reload");
    end

    // 3: one-shot load 6 with en alternating
    cyc(1, 4'd6, 0, 1, 4'd6, 1, 0, 0, "t3_load");
    for (int i = 1; i <= 7; i++) begin
      cyc(0, 4'd0, 0, 0, 4'(7 - i), 1, 0, 0, "t3_hold_en0");
      if (i < 7)
        cyc(0, 4'd0, 0, 1, 4'(6 - i), 1, 0, 0, "t3_dec_en1");
      else
        cyc(0, 4'd0, 0, 1, 4'd0, 0, 1, 1, "t3_tc");
    end

    // 4: restart mid-run, asynchronous clear mid-count, restart at Q=0
    cyc(1, 4'd8, 0, 1, 4'd8, 1, 0, 0, "t4_load");
    for (int i = 7; i >= 4; i--)
      cyc(0, 4'd0, 0, 1, 4'(i), 1, 0, 0, "t4_dec");
    cyc(1, 4'd9, 0, 1, 4'd9, 1, 0, 0, "t4_restart");
    cyc(0, 4'd0, 0, 1, 4'd8, 1, 0, 0, "t4_dec_after");
    cyc(0, 4'd0, 0, 1, 4'd7, 1, 0, 0, "t4_dec_after");
    CLR = 1'b1;
    #2;
    push_exp("t4_clr_async", 4'd0, 1'b0, 1'b0, 1'b0);
    pop_check();
    #2;
    CLR = 1'b0;
    cyc(0, 4'd0, 0, 1, 4'd0, 0, 0, 0, "t4_idle_hold");
    cyc(1, 4'd1, 0, 1, 4'd1, 1, 0, 0, "t4_load1");
    cyc(0, 4'd0, 0, 1, 4'd0, 1, 0, 0, "t4_at_zero");
    cyc(1, 4'd2, 0, 1, 4'd2, 1, 0, 0, "t4_restart_at_zero");

    // 5: load 0 one-shot, then load 0 auto-reload
    cyc(1, 4'd0, 0, 1, 4'd0, 1, 0, 0, "t5_load0");
    cyc(0, 4'd0, 0, 1, 4'd0, 0, 1, 1, "t5_tc0");
    cyc(0, 4'd0, 0, 1, 4'd0, 0, 0, 1, "t5_done");
    cyc(1, 4'd0, 1, 1, 4'd0, 1, 0, 0, "t5_load0_auto");
    for (int i = 0; i < 3; i++)
      cyc(0, 4'd0, 0, 1, 4'd0, 1, 1, 0, "t5_tc_held");
    cyc(0, 4'd0, 0, 0, 4'd0, 1, 0, 0, "t5_en0_tc_low");
    cyc(0, 4'd0, 0, 1, 4'd0, 1, 1, 0, "t5_tc_again");

`ifdef CONTADOR_DESC_PR_EN
    // 6: preset overrides start, max-period free run
    PR = 1'b1;
    cyc(1, 4'd2, 0, 1, 4'd15, 1, 0, 0, "t6_preset");
    PR = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 14; i >= 0; i--)
        cyc(0, 4'd0, 0, 1, 4'(i), 1, 0, 0, "t6_dec");
      cyc(0, 4'd0, 0, 1, 4'd15, 1, 1, 0, "t6_tc_reload");
    end
`endif

    if (sb.size() != 0) begin
      failures++;
      $error("FAIL scoreboard_leftover got=%0d entries want=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
